// File: rtl/hex_frame_capture_if.sv
// Beat bus from the encoder datapath into the hex frame capture block.
// The master drives one group of BITS_IN encoded bits per valid cycle.
interface hex_frame_capture_if #(
  parameter int BITS_IN = 2
);
  logic               in_valid;
  logic [BITS_IN-1:0] in_bits;

  modport master (
    output in_valid,
    output in_bits
  );

  modport slave (
    input in_valid,
    input in_bits
  );
endinterface

// File: rtl/hex_frame_capture.sv
// Packs encoded bit beats into nibbles and nibbles into a display frame.
// The hex word updates a whole frame at a time so the displays stay steady.
module hex_frame_capture #(
  parameter int NUM_DIGITS = 4,
  parameter int BITS_IN    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  hex_frame_capture_if.slave      beat,
  input  logic                    freeze,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    overflow,
  output logic [7:0]              frames
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int BEATS = 4 / BITS_IN;

  localparam logic [1:0] BEAT_LAST = 2'(BEATS - 1);
  localparam logic [2:0] NIB_LAST  = 3'(NUM_DIGITS - 1);

  generate
    if (!(BITS_IN == 1 || BITS_IN == 2 || BITS_IN == 4)) begin : g_bad_bits
      $error("hex_frame_capture: BITS_IN must be 1, 2 or 4");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("hex_frame_capture: NUM_DIGITS must be 1..8");
    end
  endgenerate

  logic [3:0]   asm_q;
  logic [W-1:0] work_q;
  logic [1:0]   bcnt_q;
  logic [2:0]   ncnt_q;

  logic         accept;
  logic         nib_done;
  logic         frame_last;
  logic [3:0]   asm_nxt;
  logic [W-1:0] work_nxt;

  // Earlier bits sit at the top of in_bits, so a plain concatenation
  // shifts them toward the nibble MSB.
  always_comb begin
    accept     = beat.in_valid && !clear;
    asm_nxt    = 4'({asm_q, beat.in_bits});
    work_nxt   = W'({work_q, asm_nxt});
    nib_done   = (bcnt_q == BEAT_LAST);
    frame_last = nib_done && (ncnt_q == NIB_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q  <= '0;
      work_q <= '0;
      bcnt_q <= '0;
      ncnt_q <= '0;
    end else if (clear) begin
      asm_q  <= '0;
      work_q <= '0;
      bcnt_q <= '0;
      ncnt_q <= '0;
    end else if (accept) begin
      if (!nib_done) begin
        asm_q  <= asm_nxt;
        bcnt_q <= bcnt_q + 2'd1;
      end else begin
        asm_q  <= '0;
        bcnt_q <= '0;
        if (frame_last) begin
          work_q <= '0;
          ncnt_q <= '0;
        end else begin
          work_q <= work_nxt;
          ncnt_q <= ncnt_q + 3'd1;
        end
      end
    end
  end

  // A frozen display still drains the work register; the lost frame
  // is only remembered through the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nibble_out  <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      frames      <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        overflow <= 1'b0;
      end else if (accept && frame_last) begin
        if (freeze) begin
          overflow <= 1'b1;
        end else begin
          nibble_out  <= work_nxt;
          digit_valid <= '1;
          frames      <= frames + 8'd1;
          frame_done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_frame_capture.sv
// Bench for hex_frame_capture: directed tables, corner sequences and
// random traffic against a bit-queue reference model.
module tb_hex_frame_capture;

  localparam int ND = 4;
  localparam int BI = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        freeze = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] nibble_out;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        overflow;
  logic [7:0]  frames;

  hex_frame_capture_if #(.BITS_IN(BI)) bi ();

  hex_frame_capture #(
    .NUM_DIGITS(ND),
    .BITS_IN(BI)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .beat       (bi),
    .freeze     (freeze),
    .clear      (clear),
    .nibble_out (nibble_out),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .overflow   (overflow),
    .frames     (frames)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int dcnt = 0;

  bit          mq[$];
  logic [15:0] m_nib;
  logic [3:0]  m_dv;
  logic        m_done;
  logic        m_ovf;
  logic [7:0]  m_frames;

  typedef struct {
    logic        v;
    logic [1:0]  b;
    logic [15:0] nib;
    logic        done;
    logic [7:0]  frm;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("m_nibble_out", 32'(nibble_out), 32'(m_nib));
    chk("m_digit_valid", 32'(digit_valid), 32'(m_dv));
    chk("m_frame_done", 32'(frame_done), 32'(m_done));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_frames", 32'(frames), 32'(m_frames));
  endtask

  task automatic model_reset();
    mq.delete();
    m_nib = '0;
    m_dv = '0;
    m_done = 1'b0;
    m_ovf = 1'b0;
    m_frames = '0;
  endtask

  // Frame word = all received bits of the frame read MSB-first.
  task automatic model_step(logic v, logic [1:0] b, logic fz, logic cl);
    logic [15:0] w;
    m_done = 1'b0;
    if (cl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (v) begin
      mq.push_back(b[1]);
      mq.push_back(b[0]);
      if (mq.size() == 4 * ND) begin
        w = '0;
        foreach (mq[i]) w = 16'((w << 1) | 16'(mq[i]));
        mq.delete();
        if (fz) begin
          m_ovf = 1'b1;
        end else begin
          m_nib = w;
          m_dv = '1;
          m_frames = m_frames + 8'd1;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(logic v, logic [1:0] b, logic fz, logic cl);
    bi.in_valid = v;
    bi.in_bits = b;
    freeze = fz;
    clear = cl;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_step(v, b, fz, cl);
    chk_all();
    if (frame_done) dcnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [1:0] basic[8];
  logic [1:0] f0f0[8];
  logic       fz;

  initial begin
    basic = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    f0f0  = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{v: 1'b1, b: basic[i], nib: (i == 7) ? 16'h12AF : 16'h0,
                  done: (i == 7), frm: (i == 7) ? 8'd1 : 8'd0};
    end
    vecs[8] = '{v: 1'b0, b: 2'b11, nib: 16'h12AF, done: 1'b0, frm: 8'd1};

    bi.in_valid = 1'b1;
    bi.in_bits = 2'b10;
    #1;
    model_reset();
    chk("rst_nibble_out", 32'(nibble_out), 32'h0);
    chk("rst_digit_valid", 32'(digit_valid), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_frames", 32'(frames), 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'($urandom), 2'($urandom), 1'($urandom), 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].v, vecs[i].b, 1'b0, 1'b0);
      chk("vec_nibble", 32'(nibble_out), 32'(vecs[i].nib));
      chk("vec_done", 32'(frame_done), 32'(vecs[i].done));
      chk("vec_frames", 32'(frames), 32'(vecs[i].frm));
    end

    do_reset();
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 2'($urandom), 1'b0, 1'b0);
      cyc(1'b1, basic[i], 1'b0, 1'b0);
      if (i < 7) chk("gap_no_early_done", 32'(dcnt), 32'd0);
    end
    chk("gap_nibble", 32'(nibble_out), 32'h12AF);
    chk("gap_frames", 32'(frames), 32'd1);
    chk("gap_dv", 32'(digit_valid), 32'hF);
    chk("gap_done_count", 32'(dcnt), 32'd1);

    dcnt = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'b01, 1'b1, 1'b0);
    chk("frz_nibble", 32'(nibble_out), 32'h12AF);
    chk("frz_overflow", 32'(overflow), 32'd1);
    chk("frz_frames", 32'(frames), 32'd1);
    chk("frz_no_done", 32'(dcnt), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, f0f0[i], 1'b0, 1'b0);
    chk("unfrz_nibble", 32'(nibble_out), 32'h0F0F);
    chk("unfrz_frames", 32'(frames), 32'd2);
    chk("unfrz_overflow", 32'(overflow), 32'd1);

    for (int i = 0; i < 3; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 2'($urandom), 1'b0, 1'b1);
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_nibble_held", 32'(nibble_out), 32'h0F0F);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 2'b01, 1'b0, 1'b0);
      if (i == 6) chk("clr_held_pre", 32'(nibble_out), 32'h0F0F);
    end
    chk("clr_nibble", 32'(nibble_out), 32'h5555);
    chk("clr_frames", 32'(frames), 32'd3);
    chk("clr_done", 32'(frame_done), 32'd1);

    for (int i = 0; i < 5; i++) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_nibble", 32'(nibble_out), 32'h0);
    chk("mid_rst_dv", 32'(digit_valid), 32'h0);
    chk("mid_rst_frames", 32'(frames), 32'h0);
    model_reset();
    chk_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    dcnt = 0;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) cyc(1'b0, 2'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
      end
    end
    chk("wrap_done_count", 32'(dcnt), 32'd256);
    chk("wrap_frames", 32'(frames), 32'd0);
    chk("wrap_dv", 32'(digit_valid), 32'hF);

    fz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) fz = ~fz;
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), fz,
          1'($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
